// File: rtl/animation_stepper_if.sv
// Handshake bundle between the animation sequencer and its surroundings:
// control inputs, the animation-length lookup pair (animation -> limit),
// and the frame outputs consumed by the 7-segment pattern ROM.
interface animation_stepper_if;
    logic       en;
    logic       pause;
    logic       step;
    logic       auto_mode;
    logic [5:0] anim_sel;
    logic [4:0] limit;
    logic [5:0] animation;
    logic [4:0] frame;
    logic       frame_stb;
    logic       wrap;

    modport master (
        output en, pause, step, auto_mode, anim_sel, limit,
        input  animation, frame, frame_stb, wrap
    );

    modport slave (
        input  en, pause, step, auto_mode, anim_sel, limit,
        output animation, frame, frame_stb, wrap
    );
endinterface

// File: rtl/animation_stepper.sv
// Frame sequencer for the 7-segment animation player. Paces frames with a
// clock prescaler, supports pause / single-step, manual animation selection
// and auto-advance to the next animation after LOOPS full passes.
module animation_stepper #(
    parameter int CLK_DIV = 12_000_000,
    parameter int LOOPS   = 4
) (
    input logic                clk,
    input logic                rst,
    animation_stepper_if.slave bus
);
    localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [3:0] LOOPS_4 = 4'(LOOPS);
    localparam logic [4:0] LOOPS_5 = 5'(LOOPS);

    typedef enum logic [1:0] {IDLE, SWITCH, RUN, PAUSE} state_t;

    state_t           state;
    logic [5:0]       animation_q;
    logic [4:0]       frame_q;
    logic             stb_q;
    logic             wrap_q;
    logic [PRE_W-1:0] pre;
    logic [3:0]       loop_cnt;

    logic [5:0]       eff;
    logic             at_last;
    logic             tick;
    logic             anim_change;
    logic             do_adv;
    logic [4:0]       adv_frame;
    logic [4:0]       loop_inc;
    logic [3:0]       adv_loop;
    logic             adv_switch;

    assign bus.animation = animation_q;
    assign bus.frame     = frame_q;
    assign bus.frame_stb = stb_q;
    assign bus.wrap      = wrap_q;

    // Frame-advance decision and the values a single advance would produce.
    // The >= compare makes a shrinking limit roll straight back to frame 0.
    always_comb begin
        eff         = (bus.limit == 5'd0) ? 6'd32 : {1'b0, bus.limit};
        at_last     = ({1'b0, frame_q} >= (eff - 6'd1));
        tick        = (pre == PRE_MAX);
        anim_change = !bus.auto_mode && (bus.anim_sel != animation_q);
        do_adv      = 1'b0;
        if (bus.en && !anim_change) begin
            if (state == RUN)
                do_adv = !bus.pause && tick;
            else if (state == PAUSE)
                do_adv = bus.pause ? bus.step : tick;
        end
        adv_frame  = at_last ? 5'd0 : frame_q + 5'd1;
        loop_inc   = {1'b0, loop_cnt} + 5'd1;
        adv_switch = at_last && bus.auto_mode && (loop_inc >= LOOPS_5);
        if (!at_last || loop_cnt >= LOOPS_4)
            adv_loop = loop_cnt;
        else
            adv_loop = loop_inc[3:0];
    end

    // Sequencer FSM with registered outputs; a frame advance is applied after
    // the state-specific updates so an auto-advance can redirect to SWITCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            animation_q <= 6'd0;
            frame_q     <= 5'd0;
            stb_q       <= 1'b0;
            wrap_q      <= 1'b0;
            pre         <= '0;
            loop_cnt    <= 4'd0;
        end else begin
            stb_q  <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    frame_q <= 5'd0;
                    pre     <= '0;
                    if (bus.en) begin
                        if (!bus.auto_mode)
                            animation_q <= bus.anim_sel;
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    frame_q  <= 5'd0;
                    pre      <= '0;
                    loop_cnt <= 4'd0;
                    stb_q    <= 1'b1;
                    state    <= bus.pause ? PAUSE : RUN;
                end
                RUN: begin
                    if (!bus.en) begin
                        state   <= IDLE;
                        frame_q <= 5'd0;
                        pre     <= '0;
                    end else if (anim_change) begin
                        animation_q <= bus.anim_sel;
                        state       <= SWITCH;
                    end else if (bus.pause) begin
                        state <= PAUSE;
                    end else begin
                        pre <= tick ? '0 : pre + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!bus.en) begin
                        state   <= IDLE;
                        frame_q <= 5'd0;
                        pre     <= '0;
                    end else if (anim_change) begin
                        animation_q <= bus.anim_sel;
                        state       <= SWITCH;
                    end else if (!bus.pause) begin
                        state <= RUN;
                        pre   <= tick ? '0 : pre + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (do_adv) begin
                frame_q  <= adv_frame;
                stb_q    <= 1'b1;
                wrap_q   <= at_last;
                loop_cnt <= adv_loop;
                if (adv_switch) begin
                    animation_q <= animation_q + 6'd1;
                    state       <= SWITCH;
                end
            end
        end
    end
endmodule
